// File: rtl/video_scandoubler.sv
// video_scandoubler
//
// Line-buffer scan doubler. Each incoming scanline is captured into one half of a
// ping-pong line RAM while the previously captured line is played out twice from the
// other half at the output dot rate, with its own horizontal and vertical sync timing.
//
// Ports
//   clk             system clock, all logic on the rising edge
//   reset           asynchronous, active-high reset
//   in_ce           input pixel strobe; in_color is sampled when high
//   in_color[5:0]   palette index of the incoming pixel
//   in_line_start   one-clk pulse at the start of each input scanline
//   in_frame_start  one-clk pulse at input line 0 (may coincide with in_line_start)
//   out_ce          output dot strobe, twice the in_ce rate
//   out_color[5:0]  doubled-line palette index (0 outside the visible window)
//   out_de          data enable
//   out_hsync       active-high horizontal sync
//   out_vsync       active-high vertical sync

module video_scandoubler #(
    parameter int unsigned H_TOTAL  = 341,
    parameter int unsigned H_ACTIVE = 256,
    parameter int unsigned HS_START = 280,
    parameter int unsigned HS_END   = 304,
    parameter int unsigned VS_LINE  = 243
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_ce,
    input  logic [5:0] in_color,
    input  logic       in_line_start,
    input  logic       in_frame_start,
    input  logic       out_ce,
    output logic [5:0] out_color,
    output logic       out_de,
    output logic       out_hsync,
    output logic       out_vsync
);

    localparam int unsigned HW = $clog2(H_TOTAL);
    localparam int unsigned AW = $clog2(H_ACTIVE + 1);
    localparam int unsigned RW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

    localparam logic [HW-1:0] HLast   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HActive = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HsStart = HW'(HS_START);
    localparam logic [HW-1:0] HsEnd   = HW'(HS_END);
    localparam logic [AW-1:0] WaMax   = AW'(H_ACTIVE);
    localparam logic [8:0]    VsLine  = 9'(VS_LINE);

    typedef enum logic {StIdle, StActive} out_state_e;

    // Line banks; contents survive reset.
    logic [5:0] bank0_q [H_ACTIVE];
    logic [5:0] bank1_q [H_ACTIVE];

    logic          wb_q, wb_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [HW-1:0] h_q, h_d;
    logic          cp_q, cp_d;
    out_state_e    state_q, state_d;
    logic [8:0]    ln_q, ln_d;
    logic          lv_q, lv_d;
    logic          armed_q, armed_d;
    logic [5:0]    out_color_q, out_color_d;
    logic          out_de_q, out_de_d;
    logic          out_hsync_q, out_hsync_d;
    logic          out_vsync_q, out_vsync_d;

    logic          we;
    logic          wsel;
    logic [RW-1:0] waddr;
    logic [5:0]    rd_data;
    logic          h_vis;

    always_comb begin
        wb_d        = wb_q;
        wa_d        = wa_q;
        h_d         = h_q;
        cp_d        = cp_q;
        state_d     = state_q;
        ln_d        = ln_q;
        lv_d        = lv_q;
        armed_d     = armed_q;
        out_color_d = out_color_q;
        out_de_d    = out_de_q;
        out_hsync_d = out_hsync_q;
        out_vsync_d = out_vsync_q;
        we          = 1'b0;
        wsel        = wb_q;
        waddr       = '0;
        rd_data     = '0;
        h_vis       = 1'b0;

        // Line-start actions come first so a coincident pixel or dot belongs to the new line.
        if (in_line_start) begin
            wb_d    = ~wb_q;
            wa_d    = '0;
            h_d     = '0;
            cp_d    = 1'b0;
            state_d = StActive;
            armed_d = 1'b1;
            // Second line start after reset: the read bank now holds a captured line.
            lv_d    = lv_q | armed_q;
        end

        if (in_frame_start) begin
            ln_d = '0;
        end else if (in_line_start) begin
            ln_d = ln_q + 9'd1;
        end

        // Capture side; nothing is written until the first line start after reset.
        if (in_ce && armed_d && (wa_d < WaMax)) begin
            we    = 1'b1;
            wsel  = wb_d;
            waddr = wa_d[RW-1:0];
            wa_d  = wa_d + AW'(1);
        end

        // Read bank is always the one not being written.
        rd_data = wb_d ? bank0_q[h_d[RW-1:0]] : bank1_q[h_d[RW-1:0]];
        h_vis   = (h_d < HActive);

        if (out_ce) begin
            if (state_d == StActive) begin
                out_de_d    = h_vis & lv_d;
                out_color_d = (h_vis & lv_d) ? rd_data : 6'd0;
                out_hsync_d = (h_d >= HsStart) && (h_d < HsEnd);
                // ln counts the line being captured; the one read out is ln-1.
                out_vsync_d = ((ln_d - 9'd1) == VsLine);
                if (h_d == HLast) begin
                    h_d = '0;
                    if (cp_d) begin
                        state_d = StIdle;
                        cp_d    = 1'b0;
                    end else begin
                        cp_d = 1'b1;
                    end
                end else begin
                    h_d = h_d + HW'(1);
                end
            end else begin
                out_de_d    = 1'b0;
                out_color_d = 6'd0;
                out_hsync_d = 1'b0;
                out_vsync_d = 1'b0;
                h_d         = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_q        <= 1'b0;
            wa_q        <= '0;
            h_q         <= '0;
            cp_q        <= 1'b0;
            state_q     <= StIdle;
            ln_q        <= '0;
            lv_q        <= 1'b0;
            armed_q     <= 1'b0;
            out_color_q <= 6'd0;
            out_de_q    <= 1'b0;
            out_hsync_q <= 1'b0;
            out_vsync_q <= 1'b0;
        end else begin
            wb_q        <= wb_d;
            wa_q        <= wa_d;
            h_q         <= h_d;
            cp_q        <= cp_d;
            state_q     <= state_d;
            ln_q        <= ln_d;
            lv_q        <= lv_d;
            armed_q     <= armed_d;
            out_color_q <= out_color_d;
            out_de_q    <= out_de_d;
            out_hsync_q <= out_hsync_d;
            out_vsync_q <= out_vsync_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we && !reset) begin
            if (wsel) begin
                bank1_q[waddr] <= in_color;
            end else begin
                bank0_q[waddr] <= in_color;
            end
        end
    end

    assign out_color = out_color_q;
    assign out_de    = out_de_q;
    assign out_hsync = out_hsync_q;
    assign out_vsync = out_vsync_q;

endmodule

// File: doc/video_scandoubler.md
VIDEO_SCANDOUBLER -- requirements
Module: video_scandoubler

Interface
REQ-001 SHALL have parameter H_TOTAL, default 341, output dots per output line.
REQ-002 SHALL have parameter H_ACTIVE, default 256, visible pixels per line.
REQ-003 SHALL have parameter HS_START, default 280, first output dot with out_hsync high.
REQ-004 SHALL have parameter HS_END, default 304, first output dot after out_hsync falls.
REQ-005 SHALL have parameter VS_LINE, default 243, input line index whose two output copies assert out_vsync.
REQ-006 SHALL have port clk  input  1  single system clock; all logic is on its rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port in_ce  input  1  input pixel strobe from the palette stage.
REQ-009 SHALL have port in_color  input  6  palette RAM dout, sampled when in_ce=1.
REQ-010 SHALL have port in_line_start  input  1  one-clk pulse at the start of each PPU scanline.
REQ-011 SHALL have port in_frame_start  input  1  one-clk pulse at PPU line 0; may coincide with in_line_start.
REQ-012 SHALL have port out_ce  input  1  output dot strobe; integrator guarantees exactly twice the in_ce rate.
REQ-013 SHALL have port out_color  output  6  doubled-line pixel colour index.
REQ-014 SHALL have port out_de  output  1  data enable.
REQ-015 SHALL have port out_hsync  output  1  active-high horizontal sync.
REQ-016 SHALL have port out_vsync  output  1  active-high vertical sync.

Function
REQ-017 SHALL hold two H_ACTIVE x 6 line banks (ping-pong): write bank wb, read bank rb = ~wb.
REQ-018 On in_line_start: SHALL toggle wb, clear write address wa to 0, clear output dot counter h to 0, clear copy flag cp to 0, and increment input line counter ln (9 bit); in_frame_start SHALL instead load ln to 0.
REQ-019 On in_ce with wa < H_ACTIVE: SHALL write in_color to bank wb at wa, then increment wa; at wa = H_ACTIVE it SHALL saturate and discard further pixels.
REQ-020 in_line_start and in_ce in the same clk: line-start actions SHALL apply first; the pixel SHALL be written to wa 0 of the new bank; wa becomes 1.
REQ-021 Output side states: ACTIVE (cp=0 or 1, counting) and IDLE (both copies done); on out_ce in ACTIVE, h SHALL increment; at h = H_TOTAL-1, h wraps to 0 and cp goes 0->1, or 1->IDLE.
REQ-022 IDLE SHALL hold h at 0 and outputs in blank (out_de=0, syncs low) until the next in_line_start.
REQ-023 in_line_start coinciding with out_ce: the out_ce SHALL be consumed as dot h=0, copy 0, of the new line.
REQ-024 Latency: for an out_ce at dot h, out_color/out_de/out_hsync/out_vsync SHALL update on the following clk edge and hold until the next out_ce.
REQ-025 out_color SHALL equal bank rb at address h when h < H_ACTIVE and lv=1, else 0.
REQ-026 out_de SHALL be 1 iff h < H_ACTIVE, state ACTIVE, and lv=1.
REQ-027 lv (line valid) SHALL be set at the second in_line_start after reset and stay set; before that, out_de=0 (rb holds unwritten data).
REQ-028 out_hsync SHALL be 1 iff ACTIVE and HS_START <= h < HS_END.
REQ-029 out_vsync SHALL be 1 iff ACTIVE and ln-1 = VS_LINE (line now being read out), for both copies, giving 2 lines x H_TOTAL dots.
REQ-030 ln SHALL wrap 511->0 without error if in_frame_start is missing.
REQ-031 RAM write and read of different banks in one clk SHALL never conflict; no same-bank access occurs by construction.

Reset
REQ-032 While reset=1: wb=0, wa=0, h=0, cp=0, state IDLE, ln=0, lv=0, out_color=0, out_de=0, out_hsync=0, out_vsync=0; bank contents are not cleared.
REQ-033 Reset deassertion mid-line: block SHALL stay IDLE and write nothing until the first in_line_start.

Verification
REQ-034 Reset, line A pixels 0..255 = i%64, line_start, line B -> during line B, two copies of 256 dots each with out_color = h%64, out_de=1 for h 0..255.
REQ-035 First line after reset -> out_de=0 throughout both copies; out_hsync still pulses at h 280..303.
REQ-036 300 in_ce in one line -> only first 256 stored; pixel 256..299 discarded; readback dot 255 = pixel 255.
REQ-037 in_line_start and in_ce same clk with in_color=0x2A -> next line readback dot 0 = 0x2A.
REQ-038 in_frame_start then 244 line_starts -> out_vsync=1 for exactly 2x341 out_ce dots while line 243 is read out, 0 otherwise.
REQ-039 reset asserted mid-copy-1 -> all outputs 0 asynchronously; after release, no out_de until two line_starts.
